// File: rtl/ahb_lite_master.sv
// Non-pipelined AHB-Lite initiator: turns one host command into one single
// transfer, placing write data on byte lanes and extracting read data.
module ahb_lite_master (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic [31:0] rsp_rdata,
  output logic        hsel,
  output logic [1:0]  htrans,
  output logic [3:0]  haddr,
  output logic [1:0]  hsize,
  output logic        hwrite,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [3:0]  r_addr;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        w_legal;

  function automatic logic f_legal(input logic [1:0] size, input logic [3:0] addr);
    logic ok;
    case (size)
      2'd0:    ok = 1'b1;
      2'd1:    ok = (addr[0] == 1'b0);
      2'd2:    ok = (addr[1:0] == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] f_place(input logic [1:0] size, input logic [3:0] addr,
                                          input logic [31:0] data);
    logic [31:0] v;
    case (size)
      2'd0:    v = {24'd0, data[7:0]} << {addr[1:0], 3'b000};
      2'd1:    v = {16'd0, data[15:0]} << {addr[1], 4'b0000};
      2'd2:    v = data;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] f_extract(input logic [1:0] size, input logic [3:0] addr,
                                            input logic [31:0] data);
    logic [31:0] v;
    case (size)
      2'd0:    v = (data >> {addr[1:0], 3'b000}) & 32'h0000_00FF;
      2'd1:    v = (data >> {addr[1], 4'b0000}) & 32'h0000_FFFF;
      2'd2:    v = data;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  assign w_legal = f_legal(cmd_size, cmd_addr);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_next = w_legal ? S_ADDR : S_RESP;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ADDR: w_next = S_DATA;
      S_DATA: begin
        if (hready) begin
          w_next = S_RESP;
        end else begin
          w_next = S_DATA;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch and response capture; write data is lane-placed at accept
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_write <= 1'b0;
      r_addr  <= 4'd0;
      r_size  <= 2'd0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else if (r_state == S_IDLE && cmd_valid) begin
      r_write <= cmd_write;
      r_addr  <= cmd_addr;
      r_size  <= cmd_size;
      r_wdata <= cmd_write ? f_place(cmd_size, cmd_addr, cmd_wdata) : 32'd0;
      r_err   <= ~w_legal;
      r_rdata <= 32'd0;
    end else if (r_state == S_DATA && hready) begin
      r_err   <= hresp;
      r_rdata <= (hresp || r_write) ? 32'd0 : f_extract(r_size, r_addr, hrdata);
    end
  end

  // Outputs decoded purely from the state register and latched command
  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_error = (r_state == S_RESP) ? r_err : 1'b0;
  assign rsp_rdata = (r_state == S_RESP) ? r_rdata : 32'd0;
  assign hsel      = (r_state == S_ADDR);
  assign htrans    = (r_state == S_ADDR) ? 2'b10 : 2'b00;
  assign haddr     = (r_state == S_ADDR) ? r_addr : 4'd0;
  assign hsize     = (r_state == S_ADDR) ? r_size : 2'd0;
  assign hwrite    = (r_state == S_ADDR) ? r_write : 1'b0;
  assign hwdata    = (r_state == S_DATA) ? r_wdata : 32'd0;

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

AHB-Lite initiator that issues single register transfers to the USB endpoint's AHB-Lite slave. A host-side command port is converted into one non-pipelined AHB-Lite transfer at a time. The block places write data on the correct byte lanes, waits out slave wait states and two-cycle error responses, and returns lane-extracted read data. It sits between test or firmware control logic and the endpoint slave, and it drives exactly the address and size combinations that slave decodes.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on its rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command can be accepted; high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  4  register byte address (0x0–0xD).
- cmd_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal.
- cmd_wdata  in  32  write data, right-justified (bits [8·2^size−1:0] used).
- rsp_valid  out  1  one-cycle pulse; the transfer is finished.
- rsp_error  out  1  qualified by rsp_valid; slave ERROR, misaligned access, or illegal size.
- rsp_rdata  out  32  qualified by rsp_valid; read data, zero-extended from the addressed lane. 0 for writes and errors.
- hsel  out  1  slave select.
- htrans  out  2  2'b00 IDLE, 2'b10 NONSEQ.
- haddr  out  4  transfer address.
- hsize  out  2  transfer size.
- hwrite  out  1  transfer direction.
- hwdata  out  32  write data, lane-aligned.
- hrdata  in  32  slave read data.
- hready  in  1  slave ready.
- hresp  in  1  slave response; 1 = ERROR.

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch cmd_write, cmd_addr, cmd_size and cmd_wdata.
    - If the command is legal, go to ADDR.
    - If it is not legal, go to RESP with the error flag set. No bus activity occurs.
  - ADDR: hsel=1, htrans=NONSEQ, with haddr/hsize/hwrite taken from the latched command. Always lasts exactly 1 cycle, then go to DATA.
  - DATA: hsel=0, htrans=IDLE, haddr/hsize/hwrite return to 0, and hwdata holds the lane-aligned data for writes.
    - Stay in DATA while hready=0.
    - On hready=1, capture hrdata and hresp, then go to RESP.
  - RESP: rsp_valid=1 with rsp_error/rsp_rdata. Always lasts 1 cycle, then go to IDLE.
- Legality rules:
  - cmd_size=3 is illegal.
  - A halfword requires addr[0]=0.
  - A word requires addr[1:0]=0.
- Write lane placement (little-endian):
  - byte: hwdata[8·addr[1:0] +: 8] = wdata[7:0]
  - halfword: hwdata[16·addr[1] +: 16] = wdata[15:0]
  - word: the full 32 bits
  - All unused lanes are driven 0.
- Read extraction uses the same lane selection on hrdata; the upper bits of rsp_rdata are 0.
- ERROR response from the slave:
  - The first cycle (hresp=1, hready=0) is a wait cycle. No new transfer is issued, because the block is non-pipelined.
  - The second cycle (hresp=1, hready=1) ends the transfer with rsp_error=1 and rsp_rdata=0.
- hresp=1 together with hready=1 without a preceding wait cycle is also treated as an error.

## Timing
- Reset values:
  - state=IDLE, cmd_ready=1, rsp_valid=0, rsp_error=0, rsp_rdata=0.
  - hsel=0, htrans=00, haddr=0, hsize=0, hwrite=0, hwdata=0.
- All outputs are registered or decoded from the state register only. No input-to-output combinational paths.
- Zero-wait transfer:
  - Cycle 0: command accepted.
  - Cycle 1: ADDR.
  - Cycle 2: DATA, hready=1.
  - Cycle 3: rsp_valid.
  - Cycle 4: cmd_ready=1 again.
- Each hready=0 cycle in DATA adds one cycle of latency.
- Illegal command: accepted in cycle 0, rsp_valid with error in cycle 1, and the AHB signals stay idle throughout.
- Commands presented while cmd_ready=0 are ignored; the caller holds cmd_valid.
- Reset asserted mid-transfer: immediate return to the reset values and no rsp_valid. The slave recovers through its own reset.

## Test plan
- Reset -> all outputs at their reset values and cmd_ready=1. Deassert reset with no command -> htrans stays 00 indefinitely.
- Word write, addr 0x0, wdata 0xDEADBEEF, hready=1 -> ADDR cycle with haddr=0, hsize=2, hwrite=1, htrans=10. Next cycle hwdata=0xDEADBEEF. rsp_valid 3 cycles after accept, rsp_error=0.
- Byte write, addr 0xD (flush), wdata 0x01 -> hwdata=0x00000100. Halfword read, addr 0x6, hrdata=0xABCD1234 -> rsp_rdata=0x0000ABCD.
- Byte read, addr 0x8, with hready held 0 for 3 cycles and hrdata=0x00000040 on completion -> rsp_valid exactly 6 cycles after accept, rsp_rdata=0x40.
- Word write to addr 0xC with the slave giving a two-cycle ERROR -> rsp_error=1, rsp_rdata=0, and no second NONSEQ issued. Word read at addr 0x2 -> rsp_error=1 one cycle after accept and hsel never asserted. The same no-bus-activity result applies to cmd_size=3.
- Assert n_rst during DATA with hready=0 -> outputs return to reset values asynchronously. A following word read of addr 0x4 completes normally.
